// File: rtl/program_counter_pkg.sv
// Shared next-PC select encodings and default widths for the fetch and branch units.
`default_nettype none
package program_counter_pkg;
    localparam int PC_WIDTH_DEFAULT = 12;
    localparam int PC_OFF_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_INC  = 2'b01,
        SEL_REL  = 2'b10,
        SEL_LD   = 2'b11
    } pc_sel_e;
endpackage
`default_nettype wire

// File: rtl/program_counter_dff_clr.sv
// Single-bit storage element with asynchronous active-low clear to a per-bit preset value.
`default_nettype none
module dff_clr #(
    parameter bit PRESET = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) q <= PRESET;
        else      q <= d;
    end
endmodule
`default_nettype wire

// File: rtl/program_counter.sv
// Fetch-path program counter: increment, absolute load, signed relative branch or hold.
`default_nettype none
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               OFF_W     = PC_OFF_W_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             rel,
    input  logic [OFF_W-1:0] rel_off,
    input  logic             inc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_prev,
    output logic             wrap
);
    pc_sel_e          sel;
    logic [WIDTH-1:0] off_ext;
    logic [WIDTH:0]   rel_sum;
    logic [WIDTH-1:0] inc_sum;
    logic             rel_wrap;
    logic             inc_wrap;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] prev_d;
    logic             wrap_d;

    assign off_ext  = WIDTH'($signed(rel_off));
    assign rel_sum  = {1'b0, pc} + {1'b0, off_ext};
    assign inc_sum  = pc + {{(WIDTH-1){1'b0}}, 1'b1};
    assign inc_wrap = &pc;
    // A negative offset adds as two's complement, so a borrow shows up as a missing carry.
    assign rel_wrap = rel_off[OFF_W-1] ? ~rel_sum[WIDTH] : rel_sum[WIDTH];

    always_comb begin
        if (ld)       sel = SEL_LD;
        else if (rel) sel = SEL_REL;
        else if (inc) sel = SEL_INC;
        else          sel = SEL_HOLD;
    end

    always_comb begin
        pc_d   = pc;
        prev_d = pc_prev;
        wrap_d = wrap;
        if (en) begin
            wrap_d = 1'b0;
            case (sel)
                SEL_LD: begin
                    pc_d   = ld_val;
                    prev_d = pc;
                end
                SEL_REL: begin
                    pc_d   = rel_sum[WIDTH-1:0];
                    prev_d = pc;
                    wrap_d = rel_wrap;
                end
                SEL_INC: begin
                    pc_d   = inc_sum;
                    prev_d = pc;
                    wrap_d = inc_wrap;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pc_bits
        dff_clr #(.PRESET(RESET_VEC[i])) u_pc (
            .clk(clk), .clr(clr), .d(pc_d[i]), .q(pc[i])
        );
        dff_clr #(.PRESET(RESET_VEC[i])) u_prev (
            .clk(clk), .clr(clr), .d(prev_d[i]), .q(pc_prev[i])
        );
    end

    dff_clr #(.PRESET(1'b0)) u_wrap (
        .clk(clk), .clr(clr), .d(wrap_d), .q(wrap)
    );
endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized traffic against a modulo-arithmetic model.
`default_nettype none
module tb_program_counter;
    localparam int W   = 12;
    localparam int OW  = 8;
    localparam int MOD = 1 << W;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          en = 1'b0, ld = 1'b0, rel = 1'b0, inc = 1'b0;
    logic [W-1:0]  ld_val = '0;
    logic [OW-1:0] rel_off = '0;
    logic [W-1:0]  pc, pc_prev;
    logic          wrap;

    int checks = 0;
    int failures = 0;
    int m_pc = 0, m_prev = 0;
    bit m_wrap = 1'b0;

    program_counter #(.WIDTH(W), .RESET_VEC('0), .OFF_W(OW)) dut (
        .clk(clk), .clr(clr), .en(en), .ld(ld), .ld_val(ld_val),
        .rel(rel), .rel_off(rel_off), .inc(inc),
        .pc(pc), .pc_prev(pc_prev), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic drive(bit e, bit l, int lv, bit r, int ro, bit i);
        en = e; ld = l; ld_val = W'(lv); rel = r; rel_off = OW'(ro); inc = i;
    endtask

    // Reference: integer PC, wrap means the true sum left the range [0, 2^W).
    task automatic model_edge();
        int nxt;
        if (!clr) begin
            m_pc = 0; m_prev = 0; m_wrap = 0;
        end else if (en) begin
            m_wrap = 0;
            if (ld) begin
                m_prev = m_pc; m_pc = int'(ld_val);
            end else if (rel || inc) begin
                nxt = rel ? m_pc + int'($signed(rel_off)) : m_pc + 1;
                m_prev = m_pc;
                m_wrap = (nxt < 0) || (nxt >= MOD);
                m_pc = (nxt + MOD) % MOD;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        tick();
        checks++; if (pc !== 12'h000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 12'h000); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        clr = 1'b1;
        drive(1, 0, 0, 0, 0, 1);
        repeat (5) tick();
        checks++; if (pc !== 12'h005) begin failures++; $display("FAIL count5_pc got=%h exp=%h", pc, 12'h005); end
        #2 clr = 1'b0;
        #1;
        m_pc = 0; m_prev = 0; m_wrap = 0;
        checks++; if (pc !== 12'h000) begin failures++; $display("FAIL async_clr_pc got=%h exp=000", pc); end
        checks++; if (pc_prev !== 12'h000) begin failures++; $display("FAIL async_clr_prev got=%h exp=000", pc_prev); end
        tick();
        checks++; if (pc !== 12'h000) begin failures++; $display("FAIL clr_held_pc got=%h exp=000", pc); end
        @(negedge clk) clr = 1'b1;
        tick();
        checks++; if (pc !== 12'h001) begin failures++; $display("FAIL release_pc got=%h exp=001", pc); end
    endtask

    task automatic test_inc_wrap();
        drive(1, 1, 'hFFE, 0, 0, 0);
        tick();
        checks++; if (pc !== 12'hFFE) begin failures++; $display("FAIL incw_load got=%h exp=FFE", pc); end
        drive(1, 0, 0, 0, 0, 1);
        tick();
        checks++; if (pc !== 12'hFFF || wrap !== 1'b0) begin failures++; $display("FAIL incw_fff got=%h/%b exp=FFF/0", pc, wrap); end
        tick();
        checks++; if (pc !== 12'h000 || wrap !== 1'b1) begin failures++; $display("FAIL incw_000 got=%h/%b exp=000/1", pc, wrap); end
        tick();
        checks++; if (pc !== 12'h001 || wrap !== 1'b0) begin failures++; $display("FAIL incw_after got=%h/%b exp=001/0", pc, wrap); end
    endtask

    task automatic test_rel();
        drive(1, 1, 'h010, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 'hF0, 0);
        tick();
        checks++; if (pc !== 12'h000 || wrap !== 1'b0) begin failures++; $display("FAIL rel_m16 got=%h/%b exp=000/0", pc, wrap); end
        drive(1, 0, 0, 1, 'hFF, 0);
        tick();
        checks++; if (pc !== 12'hFFF || wrap !== 1'b1 || pc_prev !== 12'h000) begin
            failures++; $display("FAIL rel_m1 got=%h/%b/%h exp=FFF/1/000", pc, wrap, pc_prev); end
        drive(0, 0, 0, 1, 'h01, 1);
        tick();
        checks++; if (wrap !== 1'b1 || pc !== 12'hFFF) begin failures++; $display("FAIL wrap_stall got=%h/%b exp=FFF/1", pc, wrap); end
        drive(1, 0, 0, 1, 'h7F, 0);
        tick();
        checks++; if (pc !== 12'h07E || wrap !== 1'b1) begin failures++; $display("FAIL rel_pos_carry got=%h/%b exp=07E/1", pc, wrap); end
    endtask

    task automatic test_priority();
        drive(1, 1, 'h100, 0, 0, 0);
        tick();
        drive(1, 1, 'h2A0, 1, 'h04, 1);
        tick();
        checks++; if (pc !== 12'h2A0 || pc_prev !== 12'h100) begin failures++; $display("FAIL prio_ld got=%h/%h exp=2A0/100", pc, pc_prev); end
        drive(1, 0, 0, 1, 'h04, 1);
        tick();
        checks++; if (pc !== 12'h2A4 || pc_prev !== 12'h2A0) begin failures++; $display("FAIL prio_rel got=%h/%h exp=2A4/2A0", pc, pc_prev); end
    endtask

    task automatic test_stall();
        drive(1, 1, 'h050, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (pc !== 12'h050 || pc_prev !== 12'h2A4) begin
                failures++; $display("FAIL stall_%0d got=%h/%h exp=050/2A4", k, pc, pc_prev); end
        end
        en = 1'b1;
        tick();
        checks++; if (pc !== 12'h051 || pc_prev !== 12'h050) begin failures++; $display("FAIL stall_release got=%h/%h exp=051/050", pc, pc_prev); end
    endtask

    task automatic test_hold();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        checks++; if (pc !== 12'h051 || pc_prev !== 12'h050) begin failures++; $display("FAIL hold got=%h/%h exp=051/050", pc, pc_prev); end
        drive(1, 0, 0, 1, 0, 0);
        tick();
        checks++; if (pc !== 12'h051 || pc_prev !== 12'h051 || wrap !== 1'b0) begin
            failures++; $display("FAIL rel_zero got=%h/%h/%b exp=051/051/0", pc, pc_prev, wrap); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), int'($urandom_range(0, MOD - 1)),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1));
            if (k % 8 == 0) begin
                ld = 1'b1;
                ld_val = ($urandom_range(0, 1) == 1) ? W'($urandom_range(MOD - 4, MOD - 1)) : W'($urandom_range(0, 3));
            end
            tick();
            checks++;
            if (pc !== W'(m_pc) || pc_prev !== W'(m_prev) || wrap !== m_wrap) begin
                failures++; errs++;
                if (errs <= 5) $display("FAIL random_%0d got=%h/%h/%b exp=%h/%h/%b",
                                        k, pc, pc_prev, wrap, W'(m_pc), W'(m_prev), m_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_wrap();
        test_rel();
        test_priority();
        test_stall();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
